resp_capture: RTL

Response-side counterpart of the stimulus benches: it samples DUT output words, buffers them in a FIFO for readback, and compacts every sample into a 32-bit MISR signature.
- Capture runs in windows of NUM_SAMPLES accepted samples.
- Sits between the DUT outputs (e.g. a 64-bit result bus) and the checker/readout logic of the harness.

---
 rtl/resp_capture.sv | 122 ++++++++++++
 1 files changed

// File: rtl/resp_capture.sv
// resp_capture: captures DUT response words into a readback FIFO and compacts every sample into a 32-bit MISR signature
// Optional feature macro: RESP_TIMEOUT_EN (idle-cycle timeout while capturing)
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   start                      arms a window of NUM_SAMPLES accepted samples
//   sample_valid, sample_data  DUT response word
//   rd_req                     pop request; rd_data/rd_valid answer one cycle later
//   busy, done                 window in progress / one-cycle end-of-window pulse
//   count, overflow            FIFO occupancy / sticky sample-dropped flag
//   signature, timeout         MISR value / sticky idle-timeout flag
module resp_capture #(
    parameter int          DATA_W      = 64,
    parameter int          DEPTH       = 16,
    parameter int          NUM_SAMPLES = 8,
    parameter logic [31:0] SIG_POLY    = 32'h04C11DB7,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     sample_valid,
    input  logic [DATA_W-1:0]        sample_data,
    input  logic                     rd_req,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [31:0]              signature,
    output logic                     timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(NUM_SAMPLES + 1);
    typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;
    state_t            state, state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [SW-1:0]     smp_cnt;
    logic              accept, push, pop, last, to_hit, arm;
    logic [31:0]       fold;

    always_comb begin
        fold = '0;
        for (int i = 0; i < DATA_W / 32; i++) fold = fold ^ sample_data[i*32 +: 32];
    end

    assign arm    = state == IDLE && start;
    assign pop    = rd_req && count != '0;
    assign accept = state == CAPTURE && sample_valid;
    // A full FIFO still takes the sample when a pop frees the head slot on the same edge.
    assign push   = accept && (count != (AW+1)'(DEPTH) || pop);
    assign last   = accept && smp_cnt == SW'(NUM_SAMPLES - 1);
    assign busy   = state != IDLE;

`ifdef RESP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] idle_cnt;
    assign to_hit = state == CAPTURE && !sample_valid && idle_cnt == TW'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else if (arm) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else if (state == CAPTURE) begin
            idle_cnt <= sample_valid ? '0 : idle_cnt + 1'b1;
            if (to_hit) timeout <= 1'b1;
        end
    end
`else
    assign to_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        state_nxt = state == IDLE    ? (start ? CAPTURE : IDLE) :
                    state == CAPTURE ? (last || to_hit ? HOLD : CAPTURE) :
                                       (count == '0 ? IDLE : HOLD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            smp_cnt   <= '0;
            signature <= '1;
            overflow  <= 1'b0;
            done      <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
        end else begin
            state    <= state_nxt;
            done     <= last || to_hit;
            rd_valid <= pop;
            count    <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (arm) begin
                signature <= '1;
                smp_cnt   <= '0;
                overflow  <= 1'b0;
            end else if (accept) begin
                smp_cnt   <= smp_cnt + 1'b1;
                // Dropped samples are still compacted so the signature covers every response.
                signature <= {signature[30:0], 1'b0} ^ (signature[31] ? SIG_POLY : 32'h0) ^ fold;
                if (!push) overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= sample_data;
    end
endmodule
